// File: rtl/led_bank_arbiter_if.sv
// Signal bundle between the LED bank arbiter, its status requesters, the blinker and the LED pins.
// The master side drives requests and patterns; the slave side is the arbiter.
interface led_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int PWM_W = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_pattern;
    logic [7:0]        idle_pattern;
    logic [PWM_W-1:0]  brightness;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        led_output;

    modport master (
        output req, req_pattern, idle_pattern, brightness,
        input  grant, busy, led_output
    );

    modport slave (
        input  req, req_pattern, idle_pattern, brightness,
        output grant, busy, led_output
    );
endinterface

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 8-LED bank with a per-grant dwell time and a blank gap between owners.
// Optional macro LED_PWM_EN gates the LED source with a global brightness PWM before the output register.
module led_bank_arbiter #(
    parameter int NREQ         = 4,
    parameter int DWELL_CYCLES = 1000000,
    parameter int GAP_CYCLES   = 100000,
    parameter int PWM_W        = 4
) (
    input logic               aclk,
    input logic               aresetn,
    led_bank_arbiter_if.slave bus
);
    localparam int IDX_W   = $clog2(NREQ);
    localparam int MAX_CNT = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t           state;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [7:0]       held_pattern;
    logic [7:0]       led_output;
    logic [7:0]       pattern [NREQ];
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             pick_valid;
    logic             owner_req;
    logic             contested;
    logic [7:0]       led_src;
    logic [7:0]       led_next;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pattern[i] = bus.req_pattern[8*i +: 8];
        end
    end

    // Search downward so the candidate closest after rr_ptr is the last one written.
    // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // rr_ptr always holds the current owner's index while in HOLD.
    assign owner_req = bus.req[rr_ptr];
    assign contested = |(bus.req & ~grant);

    always_comb begin
        case (state)
            HOLD:    led_src = held_pattern;
            GAP:     led_src = 8'h00;
            default: led_src = bus.idle_pattern;
        endcase
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_on;

    assign pwm_on   = (bus.brightness == {PWM_W{1'b1}}) || (pwm_cnt < bus.brightness);
    assign led_next = pwm_on ? led_src : 8'h00;

    always_ff @(posedge aclk) begin
        if (!aresetn) pwm_cnt <= '0;
        else          pwm_cnt <= pwm_cnt + 1'b1;
    end
`else
    logic unused_brightness;

    assign unused_brightness = ^bus.brightness;
    assign led_next          = led_src;
`endif

    // NOTE: sequential state uses <= only, so every branch below reads pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= IDX_W'(NREQ - 1);
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
            held_pattern <= 8'h00;
            led_output   <= 8'h00;
        end else begin
            led_output <= led_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state        <= HOLD;
                        grant        <= NREQ'(1) << pick_idx;
                        rr_ptr       <= pick_idx;
                        held_pattern <= pattern[pick_idx];
                        dwell_cnt    <= DWELL_LOAD;
                    end
                end
                HOLD: begin
                    if (!owner_req || (dwell_cnt == '0 && contested)) begin
                        state   <= GAP;
                        grant   <= '0;
                        gap_cnt <= GAP_LOAD;
                    end else if (dwell_cnt == '0) begin
                        // Uncontested expiry extends the grant seamlessly with a fresh pattern.
                        dwell_cnt    <= DWELL_LOAD;
                        held_pattern <= pattern[rr_ptr];
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (pick_valid) begin
                        state        <= HOLD;
                        grant        <= NREQ'(1) << pick_idx;
                        rr_ptr       <= pick_idx;
                        held_pattern <= pattern[pick_idx];
                        dwell_cnt    <= DWELL_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant      = grant;
    assign bus.busy       = (state != IDLE);
    assign bus.led_output = led_output;
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Honours LED_PWM_EN the same way the design does.
module tb_led_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int DWELL = 8;
    localparam int GAP   = 2;
    localparam int PWM_W = 4;

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_GAP  = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    led_bank_arbiter_if #(.NREQ(NREQ), .PWM_W(PWM_W)) bus ();

    led_bank_arbiter #(
        .NREQ(NREQ), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP), .PWM_W(PWM_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: who owns the bank, how long it has held it, and how long the gap has run.
    int         m_mode;
    int         m_owner;
    int         m_last;
    int         m_held;
    int         m_gap;
    int         m_pwm;
    logic [7:0] m_pat;
    logic [7:0] m_led;

    function automatic bit req_bit(int i);
        return ((bus.req >> i) & 1) != 0;
    endfunction

    function automatic int rr_winner();
        for (int k = 1; k <= NREQ; k++) begin
            if (req_bit((m_last + k) % NREQ)) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit others_want();
        for (int i = 0; i < NREQ; i++) begin
            if (i != m_owner && req_bit(i)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit pwm_on(int cnt, logic [PWM_W-1:0] br);
`ifdef LED_PWM_EN
        return (br == {PWM_W{1'b1}}) || (cnt < int'(br));
`else
        return (cnt >= 0) || (br != br);
`endif
    endfunction

    function automatic logic [NREQ-1:0] m_grant();
        return (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    endfunction

    task automatic start_grant(int w);
        m_mode  = M_HOLD;
        m_owner = w;
        m_last  = w;
        m_held  = 0;
        m_pat   = 8'(bus.req_pattern >> (8 * w));
    endtask

    task automatic model_edge();
        logic [7:0] src;
        int w;
        if (!aresetn) begin
            m_mode = M_IDLE; m_owner = -1; m_last = NREQ - 1; m_held = 0;
            m_gap = 0; m_pwm = 0; m_pat = 8'h00; m_led = 8'h00;
            return;
        end
        src   = (m_mode == M_HOLD) ? m_pat : (m_mode == M_GAP) ? 8'h00 : bus.idle_pattern;
        m_led = pwm_on(m_pwm, bus.brightness) ? src : 8'h00;
        m_pwm = (m_pwm + 1) % (1 << PWM_W);
        if (m_mode == M_IDLE) begin
            w = rr_winner();
            if (w >= 0) start_grant(w);
        end else if (m_mode == M_HOLD) begin
            m_held++;
            if (!req_bit(m_owner) || (m_held == DWELL && others_want())) begin
                m_mode = M_GAP; m_owner = -1; m_gap = 0;
            end else if (m_held == DWELL) begin
                m_held = 0;
                m_pat  = 8'(bus.req_pattern >> (8 * m_owner));
            end
        end else begin
            m_gap++;
            if (m_gap == GAP) begin
                w = rr_winner();
                if (w >= 0) start_grant(w);
                else        m_mode = M_IDLE;
            end
        end
    endtask

    // Model sees the inputs the coming edge samples; outputs are read 1 ns after that edge.
    task automatic step();
        model_edge();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_pattern(int i, logic [7:0] p);
        bus.req_pattern[8*i +: 8] = p;
    endtask

    task automatic test_reset();
        aresetn          = 1'b0;
        bus.req          = '0;
        bus.req_pattern  = '0;
        bus.idle_pattern = 8'hA5;
        bus.brightness   = '1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.led_output !== 8'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", bus.led_output); end
            checks++;
            if (bus.grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
            checks++;
            if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        end
        aresetn = 1'b1;
        step();
        checks++;
        if (bus.led_output !== 8'hA5) begin failures++; $display("FAIL release_led got=%h exp=a5", bus.led_output); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_single_owner();
        set_pattern(2, 8'h3C);
        bus.req = 4'b0100;
        step();
        checks++;
        if (bus.grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", bus.grant); end
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
        for (int c = 0; c < 30; c++) begin
            step();
            checks++;
            if (bus.led_output !== 8'h3C || bus.grant !== 4'b0100) begin
                failures++;
                $display("FAIL single_hold cyc=%0d led=%h grant=%b exp led=3c grant=0100", c, bus.led_output, bus.grant);
            end
        end
        bus.req = '0;
        repeat (4) step();
        checks++;
        if (bus.busy !== 1'b0 || bus.led_output !== 8'hA5) begin
            failures++;
            $display("FAIL single_release busy=%b led=%h exp busy=0 led=a5", bus.busy, bus.led_output);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        logic [7:0]      exp_l;
        set_pattern(0, 8'h11);
        set_pattern(1, 8'h22);
        bus.req = 4'b0011;
        for (int c = 0; c <= 20; c++) begin
            step();
            exp_g = (c < 8) ? 4'b0001 : (c < 10) ? 4'b0000 : (c < 18) ? 4'b0010 : (c < 20) ? 4'b0000 : 4'b0001;
            checks++;
            if (bus.grant !== exp_g) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, bus.grant, exp_g); end
            if (c >= 1) begin
                exp_l = (c <= 8) ? 8'h11 : (c <= 10) ? 8'h00 : (c <= 18) ? 8'h22 : 8'h00;
                checks++;
                if (bus.led_output !== exp_l) begin failures++; $display("FAIL rr_led cyc=%0d got=%h exp=%h", c, bus.led_output, exp_l); end
            end
        end
        bus.req = '0;
        repeat (4) step();
    endtask

    task automatic test_drop();
        set_pattern(3, 8'hF0);
        bus.req = 4'b1000;
        step();
        checks++;
        if (bus.grant !== 4'b1000) begin failures++; $display("FAIL drop_grant got=%b exp=1000", bus.grant); end
        repeat (2) step();
        bus.req = '0;
        step();
        checks++;
        if (bus.grant !== 4'b0000) begin failures++; $display("FAIL drop_ungrant got=%b exp=0000", bus.grant); end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (bus.led_output !== 8'h00) begin failures++; $display("FAIL drop_gap cyc=%0d got=%h exp=00", c, bus.led_output); end
        end
        step();
        checks++;
        if (bus.led_output !== 8'hA5 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle led=%h busy=%b exp led=a5 busy=0", bus.led_output, bus.busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        bus.req = 4'b1000;
        step();
        checks++;
        if (bus.grant !== 4'b1000) begin failures++; $display("FAIL midrst_grant got=%b exp=1000", bus.grant); end
        repeat (2) step();
        aresetn = 1'b0;
        bus.req = 4'b1001;
        set_pattern(0, 8'h5A);
        step();
        checks++;
        if (bus.led_output !== 8'h00 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear led=%h grant=%b busy=%b exp 00/0000/0", bus.led_output, bus.grant, bus.busy);
        end
        aresetn = 1'b1;
        step();
        checks++;
        if (bus.grant !== 4'b0001) begin failures++; $display("FAIL midrst_first got=%b exp=0001", bus.grant); end
        bus.req = '0;
        repeat (4) step();
    endtask

    task automatic test_pwm();
        int on_cnt;
        int exp_on;
        logic [PWM_W-1:0] levels [3];
        levels[0] = 4'd4; levels[1] = 4'd0; levels[2] = 4'd15;
        set_pattern(0, 8'hFF);
        bus.req = 4'b0001;
        repeat (2) step();
        for (int l = 0; l < 3; l++) begin
            bus.brightness = levels[l];
            on_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                step();
                if (bus.led_output === 8'hFF) on_cnt++;
                else if (bus.led_output !== 8'h00) begin
                    checks++;
                    failures++;
                    $display("FAIL pwm_level br=%0d got=%h exp=ff_or_00", levels[l], bus.led_output);
                end
            end
`ifdef LED_PWM_EN
            exp_on = (levels[l] == 4'd15) ? 16 : int'(levels[l]);
`else
            exp_on = 16;
`endif
            checks++;
            if (on_cnt != exp_on) begin failures++; $display("FAIL pwm_duty br=%0d on=%0d exp=%0d", levels[l], on_cnt, exp_on); end
        end
        bus.req = '0;
        bus.brightness = '1;
        repeat (4) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            aresetn = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 5) == 0) bus.req = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) set_pattern($urandom_range(0, NREQ - 1), 8'($urandom));
            if ($urandom_range(0, 7) == 0) bus.brightness = PWM_W'($urandom);
            bus.idle_pattern = 8'($urandom);
            step();
            checks++;
            if (bus.grant !== m_grant() || bus.busy !== (m_mode != M_IDLE) || bus.led_output !== m_led) begin
                failures++;
                $display("FAIL random cyc=%0d grant=%b busy=%b led=%h exp grant=%b busy=%b led=%h",
                         c, bus.grant, bus.busy, bus.led_output, m_grant(), (m_mode != M_IDLE), m_led);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_round_robin();
        test_drop();
        test_reset_mid_hold();
        test_pwm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
